piso_frame_serializer: RTL

- Parametrised successor to the single-word parallel-in/serial-out shift register.
- Serialises a frame of CHANNELS words of WIDTH bits onto one serial data line, with selectable bit order.
- Double-buffered with a valid/ready load handshake, plus word-select, frame-start and underrun outputs.
- Sits between the audio mixing datapath and the DAC serial interface; the shift strobe comes from the bit-clock generator.

---
 rtl/piso_frame_serializer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
//   Double-buffered frame serialiser. A frame of CHANNELS words, each WIDTH bits
//   wide, is accepted into a holding register over a valid/ready handshake. It
//   is then moved into a shift register and sent one bit per enable strobe on sd.
//   Channel 0 is sent first. Within each word the bit order is set by MSB_FIRST.
//   Back-to-back frames are reloaded from holding with no gap bit.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   enable       shift strobe (bit-clock tick)
//   in_data      frame; channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid     in_data valid
//   in_ready     holding register empty (0 while in reset)
//   sd           serial data
//   ws           word select (LSB of channel index)
//   ch_idx       channel currently on sd
//   frame_start  one-cycle pulse when a frame enters the shifter
//   underrun     one-cycle pulse when a frame ends with holding empty
//   busy         serialiser is in RUN
module piso_frame_serializer #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int MSB_FIRST = 1,
  localparam int FRAME    = CHANNELS * WIDTH,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W    = (FRAME > 1) ? $clog2(FRAME) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [FRAME-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                sd,
  output logic                ws,
  output logic [CH_W-1:0]     ch_idx,
  output logic                frame_start,
  output logic                underrun,
  output logic                busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  logic [FRAME-1:0]   shift_r;
  logic [FRAME-1:0]   hold_r;
  logic               hold_full_r;
  logic               ready_en_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic               frame_start_r;
  logic               underrun_r;

  logic               accept_s;
  logic               last_bit_s;
  logic               load_s;

  // Rearranges a frame so that the bit to be sent first sits at the top of the
  // shifter. After that a plain left shift yields the channel and bit order.
  function automatic logic [FRAME-1:0] order_frame(input logic [FRAME-1:0] f);
    logic [FRAME-1:0] o;
    o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (MSB_FIRST != 0) begin
          o[FRAME-1-(k*WIDTH+b)] = f[k*WIDTH+WIDTH-1-b];
        end else begin
          o[FRAME-1-(k*WIDTH+b)] = f[k*WIDTH+b];
        end
      end
    end
    return o;
  endfunction

  // Handshake and reload decode.
  always_comb begin
    accept_s   = in_valid & in_ready;
    last_bit_s = (bit_cnt_r == CNT_W'(FRAME - 1));
    if (state_r == ST_IDLE) begin
      load_s = enable & hold_full_r;
    end else begin
      load_s = enable & hold_full_r & last_bit_s;
    end
  end

  // Holding register. ready_en_r keeps in_ready low until the first clock
  // after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      ready_en_r  <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (accept_s) begin
        hold_r      <= in_data;
        hold_full_r <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end else begin
        hold_full_r <= hold_full_r;
      end
    end
  end

  // Serialiser FSM with registered frame_start / underrun pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      shift_r       <= '0;
      bit_cnt_r     <= '0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            shift_r       <= order_frame(hold_r);
            bit_cnt_r     <= '0;
            state_r       <= ST_RUN;
            frame_start_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (enable) begin
            if (!last_bit_s) begin
              shift_r   <= shift_r << 1;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else if (hold_full_r) begin
              // Seamless reload: next frame's first bit follows with no gap.
              shift_r       <= order_frame(hold_r);
              bit_cnt_r     <= '0;
              frame_start_r <= 1'b1;
            end else begin
              shift_r    <= '0;
              bit_cnt_r  <= '0;
              state_r    <= ST_IDLE;
              underrun_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          shift_r   <= '0;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    in_ready    = ready_en_r & ~hold_full_r;
    frame_start = frame_start_r;
    underrun    = underrun_r;
    if (state_r == ST_RUN) begin
      busy   = 1'b1;
      sd     = shift_r[FRAME-1];
      ch_idx = CH_W'(bit_cnt_r / CNT_W'(WIDTH));
    end else begin
      busy   = 1'b0;
      sd     = 1'b0;
      ch_idx = '0;
    end
    ws = ch_idx[0];
  end

endmodule
